tl45_scoreboard: RTL and testbench
==================================

Name: tl45_scoreboard

Overview:
- Hazard controller that sequences the decode-to-execute handoff.
- Tracks in-flight writes per architectural register (r1..r15) and stalls the decode stage on RAW or WAW hazards.
- Inserts flush bubbles after branch redirect and flags writeback bookkeeping errors.
- Sits beside the decode stage: consumes its decoded register fields and drives the decode stall input.

Parameters:
- MAX_INFLIGHT, 3, maximum outstanding register-writing instructions (total and per register); range 1..7
- FLUSH_CYCLES, 2, stall cycles forced after a flush; range 1..15

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_dec_valid  in  1  decode holds an instruction wanting to issue this cycle
- i_dec_dr  in  4  destination register
- i_dec_sr1  in  4  source register 1
- i_dec_sr2  in  4  source register 2
- i_dec_wr  in  1  instruction writes i_dec_dr
- i_dec_rd1  in  1  instruction reads i_dec_sr1
- i_dec_rd2  in  1  instruction reads i_dec_sr2
- i_wb_valid  in  1  writeback retires a register write this cycle
- i_wb_dr  in  4  register being written back
- i_flush  in  1  branch redirect at writeback; all younger instructions squashed
- o_stall  out  1  hold decode (drives decode i_pipe_stall)
- o_issue  out  1  instruction accepted this cycle
- o_inflight  out  3  total outstanding writes
- o_busy  out  15  per-register pending flag, bit k-1 = rk
- o_err  out  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset (asynchronous, any cycle, including mid-flush): all pending counters 0, inflight 0, FSM=RUN, flush counter 0, o_err 0. Combinational outputs follow: o_stall 0, o_issue 0, o_busy 0, o_inflight 0.
- Register r0:
  - Never pending; reads of r0 never hazard.
  - Writes to r0 are not counted and do not increment inflight.
  - Writeback of r0 is ignored and sets no error.
- Per-register pending counter: width clog2(MAX_INFLIGHT+1). o_busy[k-1] = (cnt[k] != 0).
- FSM states:
  - RUN → FLUSH on i_flush; load flush counter with FLUSH_CYCLES.
  - FLUSH decrements the counter each cycle; → RUN when the counter reaches 1 and i_flush is low.
  - i_flush while in FLUSH reloads FLUSH_CYCLES.
- o_stall (combinational from registered state plus current decode fields) = 1 when any of:
  - state == FLUSH
  - i_flush
  - i_dec_valid && i_dec_rd1 && sr1 != 0 && cnt[sr1] != 0
  - i_dec_valid && i_dec_rd2 && sr2 != 0 && cnt[sr2] != 0
  - i_dec_valid && i_dec_wr && dr != 0 && (cnt[dr] == MAX_INFLIGHT || inflight == MAX_INFLIGHT)
- o_stall is 0 when i_dec_valid=0 and state=RUN.
- o_issue = i_dec_valid && !o_stall.
- Issue/writeback timing:
  - On o_issue && i_dec_wr && dr != 0: cnt[dr]+1 and inflight+1 at the next edge.
  - On i_wb_valid && wb_dr != 0: cnt[wb_dr]-1 and inflight-1.
- Same-cycle events:
  - Issue and writeback to the same register: net zero change.
  - Issue and writeback to different registers: both apply; inflight unchanged.
- No bypass: the hazard check uses the registered counters. A writeback in cycle N unblocks a dependent reader in cycle N+1.
- Writeback with cnt[wb_dr]==0: counter and inflight hold (no wrap); o_err set and held until reset.
- Flush:
  - At the edge where i_flush=1, all counters and inflight clear to 0. A same-cycle writeback is discarded.
  - Issue is blocked that cycle and for FLUSH_CYCLES following cycles.
- Latency: o_stall/o_issue respond in the same cycle; counter effects are visible the next cycle.

Test Plan:
- Reset then issue ADD dr=3 (wr=1); next cycle decode reads sr1=3 → o_stall=1, o_busy[2]=1. Pulse i_wb_valid wb_dr=3 → stall drops the following cycle, o_issue=1.
- Issue reading sr1=0, sr2=0 with all counters idle; also issue with dr=0 wr=1 → o_stall=0, o_inflight stays 0.
- MAX_INFLIGHT=3: issue writes to r1, r2, r4 back-to-back → o_inflight=3. Fourth write to r5 → o_stall=1 until one writeback, then issues.
- Same cycle: issue dr=6 and wb dr=6 with cnt[6]=1 → cnt[6] stays 1, inflight unchanged. Then writeback r6 twice → second sets o_err=1 and cnt stays 0.
- With r2, r7 pending, assert i_flush one cycle → next cycle o_busy=0, o_inflight=0, o_stall=1 for exactly 2 further cycles (FLUSH_CYCLES=2), then issue resumes.
- Assert i_reset asynchronously mid-FLUSH with counters nonzero → outputs clear immediately without a clock edge; FSM=RUN after release.

Source files
------------

// File: rtl/tl45_scoreboard.sv
// Decode-side hazard controller: counts in-flight register writes, stalls
// decode on RAW/WAW/capacity hazards and holds issue off for a window after a flush.
module tl45_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dec_valid,
  input  logic [3:0]  i_dec_dr,
  input  logic [3:0]  i_dec_sr1,
  input  logic [3:0]  i_dec_sr2,
  input  logic        i_dec_wr,
  input  logic        i_dec_rd1,
  input  logic        i_dec_rd2,
  input  logic        i_wb_valid,
  input  logic [3:0]  i_wb_dr,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_issue,
  output logic [2:0]  o_inflight,
  output logic [14:0] o_busy,
  output logic        o_err
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [3:0]    fcnt_q, fcnt_d;
  logic [CW-1:0] cnt_q [1:15];
  logic [2:0]    inflight_q;
  logic          err_q;

  // Bit 0 stands for r0 and stays clear, so r0 never looks pending or full.
  logic [15:0]   busy_vec;
  logic [15:0]   full_vec;
  logic [15:1]   inc_vec;
  logic [15:1]   dec_vec;

  logic raw1, raw2, waw_full;
  logic issue_wr, wb_hit, wb_ok, wb_err;

  always_comb begin
    busy_vec = '0;
    full_vec = '0;
    for (int k = 1; k < 16; k++) begin
      busy_vec[k] = (cnt_q[k] != '0);
      full_vec[k] = (cnt_q[k] == CW'(MAX_INFLIGHT));
    end
  end

  assign raw1     = i_dec_rd1 && busy_vec[i_dec_sr1];
  assign raw2     = i_dec_rd2 && busy_vec[i_dec_sr2];
  assign waw_full = i_dec_wr && (i_dec_dr != 4'd0) &&
                    (full_vec[i_dec_dr] || (inflight_q == 3'(MAX_INFLIGHT)));

  assign o_stall  = (state_q == FLUSH) || i_flush ||
                    (i_dec_valid && (raw1 || raw2 || waw_full));
  assign o_issue  = i_dec_valid && !o_stall;

  assign issue_wr = o_issue && i_dec_wr && (i_dec_dr != 4'd0);
  assign wb_hit   = i_wb_valid && (i_wb_dr != 4'd0);
  assign wb_ok    = wb_hit && busy_vec[i_wb_dr];
  assign wb_err   = wb_hit && !busy_vec[i_wb_dr];

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int k = 1; k < 16; k++) begin
      inc_vec[k] = issue_wr && (i_dec_dr == 4'(k));
      dec_vec[k] = wb_ok && (i_wb_dr == 4'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: the counter array is only 15 small entries and must read zero
      // straight out of reset, so it is reset like any other register.
      for (int k = 1; k < 16; k++) cnt_q[k] <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else if (i_flush) begin
      // Squash everything younger than the branch, including this cycle's writeback.
      for (int k = 1; k < 16; k++) cnt_q[k] <= '0;
      inflight_q <= '0;
    end else begin
      for (int k = 1; k < 16; k++) begin
        if (inc_vec[k] && !dec_vec[k])
          cnt_q[k] <= cnt_q[k] + CW'(1);
        else if (dec_vec[k] && !inc_vec[k])
          cnt_q[k] <= cnt_q[k] - CW'(1);
      end
      unique case ({issue_wr, wb_ok})
        2'b10:   inflight_q <= inflight_q + 3'd1;
        2'b01:   inflight_q <= inflight_q - 3'd1;
        default: inflight_q <= inflight_q;
      endcase
      if (wb_err) err_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (i_flush) begin
          state_d = FLUSH;
          fcnt_d  = 4'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (i_flush) begin
          fcnt_d = 4'(FLUSH_CYCLES);
        end else if (fcnt_q == 4'd1) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
    endcase
  end

  assign o_inflight = inflight_q;
  assign o_busy     = busy_vec[15:1];
  assign o_err      = err_q;

endmodule

// File: tb/tb_tl45_scoreboard.sv
// Scoreboard bench for tl45_scoreboard: a driver pushes expected outputs from a
// counting reference model, a negedge monitor pops and compares them.
module tb_tl45_scoreboard;

  localparam int MAX_INFLIGHT = 3;
  localparam int FLUSH_CYCLES = 2;

  logic        i_clk, i_reset;
  logic        i_dec_valid, i_dec_wr, i_dec_rd1, i_dec_rd2;
  logic [3:0]  i_dec_dr, i_dec_sr1, i_dec_sr2;
  logic        i_wb_valid, i_flush;
  logic [3:0]  i_wb_dr;
  logic        o_stall, o_issue, o_err;
  logic [2:0]  o_inflight;
  logic [14:0] o_busy;

  tl45_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_dec_valid(i_dec_valid), .i_dec_dr(i_dec_dr), .i_dec_sr1(i_dec_sr1),
    .i_dec_sr2(i_dec_sr2), .i_dec_wr(i_dec_wr), .i_dec_rd1(i_dec_rd1),
    .i_dec_rd2(i_dec_rd2), .i_wb_valid(i_wb_valid), .i_wb_dr(i_wb_dr),
    .i_flush(i_flush), .o_stall(o_stall), .o_issue(o_issue),
    .o_inflight(o_inflight), .o_busy(o_busy), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mon_n = 0;
  logic [20:0] exp_q [$];

  // Reference model: pending writes per register, remaining flush window, sticky error.
  int m_cnt [16];
  int m_flush_left;
  bit m_err;

  function automatic logic [20:0] dut_vec();
    return {o_stall, o_issue, o_inflight, o_busy, o_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_total();
    int s = 0;
    for (int k = 1; k < 16; k++) s += m_cnt[k];
    return s;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    m_flush_left = 0;
    m_err = 1'b0;
  endfunction

  // Outputs the spec predicts for the inputs currently on the pins.
  function automatic logic [20:0] model_out();
    bit hz, st, is;
    logic [14:0] busy;
    hz = 1'b0;
    if (i_dec_rd1 && i_dec_sr1 != 0 && m_cnt[i_dec_sr1] > 0) hz = 1'b1;
    if (i_dec_rd2 && i_dec_sr2 != 0 && m_cnt[i_dec_sr2] > 0) hz = 1'b1;
    if (i_dec_wr && i_dec_dr != 0 &&
        (m_cnt[i_dec_dr] == MAX_INFLIGHT || m_total() == MAX_INFLIGHT)) hz = 1'b1;
    st = (m_flush_left > 0) || i_flush || (i_dec_valid && hz);
    is = i_dec_valid && !st;
    for (int k = 1; k < 16; k++) busy[k-1] = (m_cnt[k] > 0);
    return {st, is, 3'(m_total()), busy, m_err};
  endfunction

  function automatic void model_advance(input bit issued);
    int wbr;
    bit wb_ok;
    wbr = int'(i_wb_dr);
    wb_ok = 1'b0;
    if (i_flush) begin
      for (int k = 0; k < 16; k++) m_cnt[k] = 0;
      m_flush_left = FLUSH_CYCLES;
    end else begin
      if (m_flush_left > 0) m_flush_left--;
      if (i_wb_valid && wbr != 0) begin
        if (m_cnt[wbr] == 0) m_err = 1'b1;
        else wb_ok = 1'b1;
      end
      if (issued && i_dec_wr && i_dec_dr != 0) m_cnt[i_dec_dr]++;
      if (wb_ok) m_cnt[wbr]--;
    end
  endfunction

  task automatic step(input int dv, input int dr, input int sr1, input int sr2,
                      input int wr, input int rd1, input int rd2,
                      input int wbv, input int wbdr, input int fl);
    logic [20:0] e;
    @(posedge i_clk);
    #1;
    i_dec_valid = (dv != 0);
    i_dec_dr    = 4'(dr);
    i_dec_sr1   = 4'(sr1);
    i_dec_sr2   = 4'(sr2);
    i_dec_wr    = (wr != 0);
    i_dec_rd1   = (rd1 != 0);
    i_dec_rd2   = (rd2 != 0);
    i_wb_valid  = (wbv != 0);
    i_wb_dr     = 4'(wbdr);
    i_flush     = (fl != 0);
    e = model_out();
    exp_q.push_back(e);
    model_advance(e[19]);
  endtask

  task automatic expect_now(input string name, input bit st, input bit is, input int inf,
                            input logic [14:0] busy, input bit er);
    #2;
    check(name, 32'(dut_vec()), 32'({st, is, 3'(inf), busy, er}));
  endtask

  task automatic idle_inputs();
    i_dec_valid = 1'b0; i_dec_dr = '0; i_dec_sr1 = '0; i_dec_sr2 = '0;
    i_dec_wr = 1'b0; i_dec_rd1 = 1'b0; i_dec_rd2 = 1'b0;
    i_wb_valid = 1'b0; i_wb_dr = '0; i_flush = 1'b0;
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string name);
    @(posedge i_clk);
    #1;
    idle_inputs();
    #1;
    check({name, " pre"}, 32'(o_stall), 32'(m_flush_left > 0));
    i_reset = 1'b1;
    #1;
    check({name, " async"}, 32'(dut_vec()), 32'(0));
    m_reset();
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    #1;
    check({name, " released"}, 32'(dut_vec()), 32'(0));
  endtask

  initial begin : monitor
    logic [20:0] e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle %0d outputs", mon_n), 32'(dut_vec()), 32'(e));
        mon_n++;
      end
    end
  end

  initial begin : driver
    int pend [$];
    int dv, dr, sr1, sr2, wr, rd1, rd2, wbv, wbdr, fl;
    i_reset = 1'b1;
    idle_inputs();
    m_reset();
    #2;
    check("reset state", 32'(dut_vec()), 32'(0));
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    step(0,0,0,0,0,0,0,0,0,0); expect_now("idle after reset", 0,0,0,15'h0000,0);
    step(1,3,0,0,1,0,0,0,0,0); expect_now("issue r3",         0,1,0,15'h0000,0);
    step(1,0,3,0,0,1,0,0,0,0); expect_now("raw r3",           1,0,1,15'h0004,0);
    step(1,0,3,0,0,1,0,1,3,0); expect_now("raw r3 wb cycle",  1,0,1,15'h0004,0);
    step(1,0,3,0,0,1,0,0,0,0); expect_now("raw r3 released",  0,1,0,15'h0000,0);
    step(1,0,0,0,0,1,1,0,0,0); expect_now("read r0",          0,1,0,15'h0000,0);
    step(1,0,0,0,1,0,0,0,0,0); expect_now("write r0",         0,1,0,15'h0000,0);
    step(0,0,0,0,0,0,0,0,0,0); expect_now("r0 not counted",   0,0,0,15'h0000,0);

    step(1,1,0,0,1,0,0,0,0,0);
    step(1,2,0,0,1,0,0,0,0,0);
    step(1,4,0,0,1,0,0,0,0,0);
    step(1,5,0,0,1,0,0,0,0,0); expect_now("inflight full",    1,0,3,15'h000B,0);
    step(1,5,0,0,1,0,0,1,1,0); expect_now("full wb cycle",    1,0,3,15'h000B,0);
    step(1,5,0,0,1,0,0,0,0,0); expect_now("full released",    0,1,2,15'h000A,0);
    step(0,0,0,0,0,0,0,1,2,0);
    step(0,0,0,0,0,0,0,1,4,0);
    step(0,0,0,0,0,0,0,1,5,0);
    step(0,0,0,0,0,0,0,0,0,0); expect_now("drained",          0,0,0,15'h0000,0);

    step(1,6,0,0,1,0,0,0,0,0);
    step(1,6,0,0,1,0,0,1,6,0); expect_now("issue+wb r6",      0,1,1,15'h0020,0);
    step(0,0,0,0,0,0,0,1,6,0); expect_now("r6 net zero",      0,0,1,15'h0020,0);
    step(0,0,0,0,0,0,0,1,6,0); expect_now("r6 empty wb",      0,0,0,15'h0000,0);
    step(0,0,0,0,0,0,0,0,0,0); expect_now("err sticky",       0,0,0,15'h0000,1);

    step(1,2,0,0,1,0,0,0,0,0);
    step(1,7,0,0,1,0,0,0,0,0);
    step(1,0,0,0,0,0,0,0,0,1); expect_now("flush cycle",      1,0,2,15'h0042,1);
    step(1,0,0,0,0,0,0,0,0,0); expect_now("flush +1",         1,0,0,15'h0000,1);
    step(1,0,0,0,0,0,0,0,0,0); expect_now("flush +2",         1,0,0,15'h0000,1);
    step(1,0,0,0,0,0,0,0,0,0); expect_now("flush done",       0,1,0,15'h0000,1);

    step(1,9,0,0,1,0,0,0,0,0);
    async_reset("reset run");
    step(0,0,0,0,0,0,0,0,0,1);
    step(0,0,0,0,0,0,0,0,0,0);
    async_reset("reset flush");
    step(1,0,0,0,0,0,0,0,0,0); expect_now("run after reset",  0,1,0,15'h0000,0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset("reset random");
      end else begin
        pend.delete();
        for (int k = 1; k < 16; k++) if (m_cnt[k] > 0) pend.push_back(k);
        dv   = int'($urandom_range(0, 9) < 7);
        dr   = int'($urandom_range(0, 7));
        sr1  = int'($urandom_range(0, 7));
        sr2  = int'($urandom_range(0, 7));
        wr   = int'($urandom_range(0, 9) < 6);
        rd1  = int'($urandom_range(0, 1));
        rd2  = int'($urandom_range(0, 1));
        wbv  = int'($urandom_range(0, 9) < 4);
        if (pend.size() > 0 && $urandom_range(0, 4) != 0)
          wbdr = pend[$urandom_range(0, pend.size() - 1)];
        else
          wbdr = int'($urandom_range(0, 7));
        fl   = int'($urandom_range(0, 39) == 0);
        step(dv, dr, sr1, sr2, wr, rd1, rd2, wbv, wbdr, fl);
      end
    end

    step(0,0,0,0,0,0,0,0,0,0);
    repeat (3) @(posedge i_clk);
    check("queue drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
